// File: rtl/vlc_frame_packer_if.sv
// rtl/vlc_frame_packer_if.sv - sample input and AXI4-Stream output bundle for vlc_frame_packer
//
// Purpose: groups the push-only sample input and the AXI4-Stream output of the
// frame packer so both ends can be connected through one port.
// Signals:
//   s_data / s_valid      limiter-gated sample and its strobe (no ready)
//   m_axis_tdata          output sample
//   m_axis_tvalid         output valid
//   m_axis_tready         downstream ready
//   m_axis_tlast          last sample of a frame
//   m_axis_tuser          on the tlast beat: frame lost at least one sample
// Modports:
//   master  the packer itself (consumes samples, drives the stream)
//   slave   the surrounding environment (drives samples, consumes the stream)
interface vlc_frame_packer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  modport master (
    input  s_data, s_valid, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    output s_data, s_valid, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/vlc_frame_packer.sv
// rtl/vlc_frame_packer.sv - packs limiter-gated samples into framed AXI4-Stream
//
// Purpose: captures every s_valid sample into a small first-word-fall-through
// FIFO and emits it as an AXI4-Stream, marking every FRAME_LEN-th sample with
// tlast. Samples that do not fit are dropped and counted; a frame that lost
// samples is flagged with tuser on its tlast beat.
// Ports:
//   clk          single clock, all logic on posedge
//   reset        synchronous, active-high
//   bus          vlc_frame_packer_if.master (s_data/s_valid in, m_axis_* out)
//   overflow     sticky, set by the first dropped sample
//   drop_count   dropped samples, saturates at 16'hFFFF
//   frame_count  tlast handshakes delivered, wraps
module vlc_frame_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 224,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  vlc_frame_packer_if.master      bus,
  output logic                    overflow,
  output logic [15:0]             drop_count,
  output logic [15:0]             frame_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_RSV  = (PW + 1)'(FIFO_DEPTH - 1);

  // Entry layout: {tuser, tlast, data}
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     cnt;
  logic [IW-1:0]   idx;
  logic            err;

  logic            is_last;
  logic            can_write;
  logic            push;
  logic            drop;
  logic            pop;
  logic            head_valid;
  logic [EW-1:0]   head;

  // The top slot is held back for last samples so a frame boundary survives
  // a stall; judged on the registered cnt, a same-cycle pop earns no credit.
  always_comb begin
    is_last   = (idx == LAST_IDX);
    can_write = is_last ? (cnt < CNT_FULL) : (cnt < CNT_RSV);
    push      = bus.s_valid & can_write;
    drop      = bus.s_valid & ~can_write;
    pop       = head_valid & bus.m_axis_tready;
  end

  // Payload is forced to zero while empty so the stream is clean after reset
  // even though the storage array itself is never cleared.
  always_comb begin
    head_valid = (cnt != '0);
    head       = head_valid ? mem[rd_ptr] : '0;
    bus.m_axis_tvalid = head_valid;
    bus.m_axis_tuser  = head[EW-1];
    bus.m_axis_tlast  = head[EW-2];
    bus.m_axis_tdata  = head[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {is_last & err, is_last, bus.s_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      idx         <= '0;
      err         <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      // The frame position advances on every strobe, dropped or not, so a
      // stall never shifts later frame boundaries.
      if (bus.s_valid) begin
        idx <= is_last ? '0 : idx + 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (bus.m_axis_tlast) begin
          frame_count <= frame_count + 1'b1;
        end
      end

      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      // A dropped last sample keeps err set, so the flag rides on the next
      // tlast that actually gets written (the merged frame).
      if (drop) begin
        err      <= 1'b1;
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end else if (push && is_last) begin
        err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vlc_frame_packer.sv
// tb/tb_vlc_frame_packer.sv - self-checking bench for vlc_frame_packer
//
// Purpose: drives two packer instances (FRAME_LEN 224 and 16, both DEPTH 16)
// with directed samples and checks the stream, flags and counters.
module tb_vlc_frame_packer;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic        ovf_a, ovf_b;
  logic [15:0] drop_a, drop_b, fr_a, fr_b;

  int total = 0;
  int bad   = 0;

  vlc_frame_packer_if #(.DATA_WIDTH(8)) bus_a ();
  vlc_frame_packer_if #(.DATA_WIDTH(8)) bus_b ();

  vlc_frame_packer #(.DATA_WIDTH(8), .FRAME_LEN(224), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .overflow(ovf_a), .drop_count(drop_a), .frame_count(fr_a)
  );

  vlc_frame_packer #(.DATA_WIDTH(8), .FRAME_LEN(16), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .overflow(ovf_b), .drop_count(drop_b), .frame_count(fr_b)
  );

  always #5 clk = ~clk;

  // Beats accepted by instance A, as {tuser, tlast, tdata}
  logic [9:0] beats_a [$];

  always @(negedge clk) begin
    if (!rst_a && bus_a.m_axis_tvalid && bus_a.m_axis_tready) begin
      beats_a.push_back({bus_a.m_axis_tuser, bus_a.m_axis_tlast, bus_a.m_axis_tdata});
    end
  end

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        rdy;
    logic        etv;
    logic [7:0]  ed;
    logic        el;
    logic        eu;
    logic [15:0] edrop;
    logic        eovf;
    logic [15:0] efr;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic sv, logic [7:0] sd, logic rdy, logic etv,
                              logic [7:0] ed, logic el, logic eu,
                              logic [15:0] edrop, logic eovf, logic [15:0] efr);
    vec_t v;
    v.sv = sv; v.sd = sd; v.rdy = rdy; v.etv = etv; v.ed = ed;
    v.el = el; v.eu = eu; v.edrop = edrop; v.eovf = eovf; v.efr = efr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    bus_a.s_valid = 1'b0;
    tick();
    rst_a = 1'b0;
    beats_a.delete();
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    bus_b.s_valid = 1'b0;
    tick();
    rst_b = 1'b0;
  endtask

  task automatic send_a(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.s_valid = 1'b1;
      bus_a.s_data  = 8'(i);
      tick();
    end
    bus_a.s_valid = 1'b0;
  endtask

  task automatic drain_a();
    int w;
    w = 0;
    while (bus_a.m_axis_tvalid && w < 40) begin
      tick();
      w++;
    end
    chk("drain_a", 32'(bus_a.m_axis_tvalid), 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input int n);
    logic [9:0] b;
    chk($sformatf("%s_beats", tag), 32'(beats_a.size()), 32'(n));
    for (int i = 0; i < beats_a.size() && i < n; i++) begin
      b = beats_a[i];
      chk($sformatf("%s_data%0d", tag, i), 32'(b[7:0]), 32'(i % 256));
      chk($sformatf("%s_last%0d", tag, i), 32'(b[8]), 32'((i % 224) == 223));
      chk($sformatf("%s_user%0d", tag, i), 32'(b[9]), 32'd0);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      bus_b.s_valid       = tbl[i].sv;
      bus_b.s_data        = tbl[i].sd;
      bus_b.m_axis_tready = tbl[i].rdy;
      tick();
      chk($sformatf("%s_tvalid%0d", tag, i), 32'(bus_b.m_axis_tvalid), 32'(tbl[i].etv));
      if (tbl[i].etv) begin
        chk($sformatf("%s_tdata%0d", tag, i), 32'(bus_b.m_axis_tdata), 32'(tbl[i].ed));
        chk($sformatf("%s_tlast%0d", tag, i), 32'(bus_b.m_axis_tlast), 32'(tbl[i].el));
        chk($sformatf("%s_tuser%0d", tag, i), 32'(bus_b.m_axis_tuser), 32'(tbl[i].eu));
      end
      chk($sformatf("%s_drop%0d", tag, i), 32'(drop_b), 32'(tbl[i].edrop));
      chk($sformatf("%s_ovf%0d", tag, i), 32'(ovf_b), 32'(tbl[i].eovf));
      chk($sformatf("%s_frames%0d", tag, i), 32'(fr_b), 32'(tbl[i].efr));
    end
    bus_b.s_valid = 1'b0;
  endtask

  initial begin
    bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.m_axis_tready = 1'b1;
    bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.m_axis_tready = 1'b0;

    // Reset state
    reset_a();
    reset_b();
    chk("rst_tvalid", 32'(bus_b.m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(bus_b.m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(bus_b.m_axis_tlast), 32'd0);
    chk("rst_tuser", 32'(bus_b.m_axis_tuser), 32'd0);
    chk("rst_ovf", 32'(ovf_b), 32'd0);
    chk("rst_drop", 32'(drop_b), 32'd0);
    chk("rst_frames", 32'(fr_b), 32'd0);

    // T1 nominal frame
    send_a(224);
    drain_a();
    check_stream("t1", 224);
    chk("t1_frames", 32'(fr_a), 32'd1);
    chk("t1_ovf", 32'(ovf_a), 32'd0);
    chk("t1_drop", 32'(drop_a), 32'd0);

    // T2 two frames back to back
    reset_a();
    send_a(448);
    drain_a();
    check_stream("t2", 448);
    chk("t2_frames", 32'(fr_a), 32'd2);
    chk("t2_ovf", 32'(ovf_a), 32'd0);

    // T5 reset in the middle of a frame
    reset_a();
    send_a(100);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    beats_a.delete();
    chk("t5_tvalid_after_rst", 32'(bus_a.m_axis_tvalid), 32'd0);
    chk("t5_frames_after_rst", 32'(fr_a), 32'd0);
    chk("t5_drop_after_rst", 32'(drop_a), 32'd0);
    send_a(224);
    drain_a();
    check_stream("t5", 224);
    chk("t5_frames", 32'(fr_a), 32'd1);

    // T3 stall with FRAME_LEN 16: 15 regular slots, reserved slot takes idx 15,
    // idx 16..19 (next frame 0..3) dropped; the next tlast carries tuser
    tbl.delete();
    for (int k = 0; k < 20; k++)
      tbl.push_back(mk(1'b1, 8'(k), 1'b0, 1'b1, 8'd0, 1'b0, 1'b0,
                       16'((k >= 16) ? k - 15 : 0), (k >= 16), 16'd0));
    for (int j = 0; j < 16; j++)
      tbl.push_back(mk(1'b0, 8'd0, 1'b1, (j < 15), 8'(j + 1), (j == 14), 1'b0,
                       16'd4, 1'b1, 16'((j == 15) ? 1 : 0)));
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(1'b1, 8'(100 + k), 1'b1, 1'b1, 8'(100 + k), (k == 11), (k == 11),
                       16'd4, 1'b1, 16'd1));
    tbl.push_back(mk(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd4, 1'b1, 16'd2));
    run_table("t3");

    // T4 hold: payload must not move while tready is low
    reset_b();
    tbl.delete();
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b1, 8'(50 + k), 1'b0, 1'b1, 8'd50, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0));
    for (int t = 0; t < 10; t++)
      tbl.push_back(mk(1'b0, 8'd0, ((t % 2) == 0), ((t / 2 + 1) < 5), 8'(50 + t / 2 + 1),
                       1'b0, 1'b0, 16'd0, 1'b0, 16'd0));
    run_table("t4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
